ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-master Wishbone arbiter that shares the single RAM data port (port 2) between the CPU data-memory master and the DMA master. It sits between the memory commutator's RAM-side data path and the dual-port RAM and replaces the combinational DMA-over-CPU priority mux with a registered, round-robin, transfer-locked grant. Each transfer runs to completion (slave ack or timeout) before the port is re-arbitrated.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max slave wait cycles in BUSY; 1..255; counter is 8 bits

Ports:
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst  in  1  reset, asynchronous, active-low
- cpu_wb_stb_i  in  1  CPU data request
- cpu_wb_we_i  in  1  CPU write enable
- cpu_wb_addr_i  in  ADDR_W  CPU address
- cpu_wb_data_i  in  DATA_W  CPU write data
- cpu_wb_ack_o  out  1  CPU ack, one-cycle pulse
- cpu_wb_data_o  out  DATA_W  CPU read data, valid with ack
- cpu_wb_err_o  out  1  CPU timeout error, valid with ack
- dma_wb_stb_i, dma_wb_we_i, dma_wb_addr_i, dma_wb_data_i  in  1/1/ADDR_W/DATA_W  DMA request side, as CPU
- dma_wb_ack_o, dma_wb_data_o, dma_wb_err_o  out  1/DATA_W/1  DMA response side, as CPU
- ram_wb_stb_o  out  1  RAM request
- ram_wb_we_o  out  1  RAM write enable
- ram_wb_addr_o  out  ADDR_W  RAM address
- ram_wb_data_o  out  DATA_W  RAM write data
- ram_wb_ack_i  in  1  RAM ack
- ram_wb_data_i  in  DATA_W  RAM read data

## Operation
- State machine: IDLE, BUSY, DONE.
- IDLE: sample both stb. One requester -> grant it. Both -> grant the one not in last_grant (round-robin). Latch we/addr/data of winner into RAM output regs, set ram_wb_stb_o=1, update last_grant, go BUSY. None -> stay.
- BUSY: hold RAM outputs stable. ram_wb_ack_i=1 -> capture ram_wb_data_i, clear ram_wb_stb_o, go DONE.
- DONE: granted master's ack_o=1 for exactly one cycle with captured data (zero for writes is not required; data passes through regardless); err_o=0. Next state IDLE. Non-granted master's ack/err stay 0.
- RAM ack outside BUSY ignored. Master dropping stb during BUSY: transfer still completes, ack still pulsed.
- Masters must hold stb/we/addr/data until their ack; inputs are only sampled in IDLE.
- Reset (any time, incl. mid-transfer): state IDLE, all outputs 0, data regs 0, last_grant=DMA (CPU wins first tie), timeout counter 0. Aborted transfer produces no ack.

## Timing
- Master stb high in IDLE at cycle N -> ram_wb_stb_o high at N+1.
- RAM ack at cycle M (M >= N+1) -> ram_wb_stb_o low and master ack high at M+1; IDLE at M+2.
- Minimum: 3 cycles per transfer with zero-wait RAM; sustained contention alternates CPU/DMA.
- Master ack cycle: master deasserts or reissues stb; new stb first sampled at M+2.

## Configuration
- ARB_TIMEOUT_EN defined: 8-bit counter clears on entering BUSY, increments each BUSY cycle without ack; reaching TIMEOUT -> clear ram_wb_stb_o, go DONE with ack=1, err_o=1, data_o=0. Ack and timeout in same cycle -> ack wins, err=0.
- Undefined: no counter; BUSY waits indefinitely; err outputs tied 0; TIMEOUT unused.

## Structure
- Shared package selen_arb_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), grant constants (GRANT_CPU=1'b0, GRANT_DMA=1'b1), TIMEOUT width constant.
- Sub-module arb_timeout_cnt (clear, enable, expired), instantiated only under ARB_TIMEOUT_EN.

## Test plan
- Reset with both stb high -> all outputs 0; after sys_rst rises CPU granted first, ram_wb_stb_o at next cycle.
- CPU read addr 0x8010 only, RAM acks 2 cycles after stb with 0xDEADBEEF -> cpu_wb_ack_o one pulse with data 0xDEADBEEF, dma_wb_ack_o never high.
- CPU and DMA writes held continuously, 4 transfers -> grant order CPU, DMA, CPU, DMA; ram_wb_addr_o/data_o match each owner.
- DMA write pending, sys_rst pulsed low while BUSY -> ram_wb_stb_o drops asynchronously, no DMA ack, next grant after reset is CPU.
- ARB_TIMEOUT_EN, TIMEOUT=4, RAM never acks -> ram_wb_stb_o high 4 cycles, then ack_o=1, err_o=1, data_o=0; without macro, stb stays high 300 cycles, no ack.
- Spurious ram_wb_ack_i in IDLE -> no state change, no master ack.

Source files
------------

// File: rtl/selen_arb_pkg.sv
// Shared definitions for the RAM data-port arbiter: FSM encoding, grant
// identifiers and the timeout counter width.
package selen_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } arb_state_e;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DMA = 1'b1;

    localparam int unsigned TO_CNT_W = 8;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Slave-wait counter for the RAM port arbiter. Cleared while the arbiter is
// idle, counts BUSY cycles without an ack, and flags the cycle in which the
// count reaches TIMEOUT.
module arb_timeout_cnt
    import selen_arb_pkg::*;
#(
    parameter int unsigned CNT_W   = TO_CNT_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This BUSY cycle is the TIMEOUT-th one without an ack.
    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin, transfer-locked arbiter sharing the RAM data port between the
// CPU data master and the DMA master. A grant is held until the RAM acks
// (or, with ARB_TIMEOUT_EN defined, until the slave-wait timeout expires).
// Optional feature macro: ARB_TIMEOUT_EN.
module ram_port_arbiter
    import selen_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    // CPU data master
    input  logic              cpu_wb_stb_i,
    input  logic              cpu_wb_we_i,
    input  logic [ADDR_W-1:0] cpu_wb_addr_i,
    input  logic [DATA_W-1:0] cpu_wb_data_i,
    output logic              cpu_wb_ack_o,
    output logic [DATA_W-1:0] cpu_wb_data_o,
    output logic              cpu_wb_err_o,
    // DMA master
    input  logic              dma_wb_stb_i,
    input  logic              dma_wb_we_i,
    input  logic [ADDR_W-1:0] dma_wb_addr_i,
    input  logic [DATA_W-1:0] dma_wb_data_i,
    output logic              dma_wb_ack_o,
    output logic [DATA_W-1:0] dma_wb_data_o,
    output logic              dma_wb_err_o,
    // RAM port 2
    output logic              ram_wb_stb_o,
    output logic              ram_wb_we_o,
    output logic [ADDR_W-1:0] ram_wb_addr_o,
    output logic [DATA_W-1:0] ram_wb_data_o,
    input  logic              ram_wb_ack_i,
    input  logic [DATA_W-1:0] ram_wb_data_i
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ram_port_arbiter: TIMEOUT must be in 1..255");
    end

    arb_state_e        state_q;
    logic              last_grant_q;  // owner of the current/most recent transfer
    logic              ram_stb_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              dma_ack_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic              win_grant;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

`ifdef ARB_TIMEOUT_EN
    logic cpu_err_q;
    logic dma_err_q;
    logic to_expired;
    logic to_hit;

    arb_timeout_cnt #(
        .CNT_W   (TO_CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clear_i   (state_q == StIdle),
        .enable_i  ((state_q == StBusy) && !ram_wb_ack_i),
        .expired_o (to_expired)
    );

    // A same-cycle ack takes precedence over the timeout.
    assign to_hit = (state_q == StBusy) && !ram_wb_ack_i && to_expired;
`endif

    // Pick the winner among the current requesters; ties go to whoever did not
    // own the previous transfer.
    always_comb begin
        win_grant = GRANT_CPU;
        if (cpu_wb_stb_i && dma_wb_stb_i) begin
            win_grant = ~last_grant_q;
        end else if (dma_wb_stb_i) begin
            win_grant = GRANT_DMA;
        end
        win_we    = (win_grant == GRANT_DMA) ? dma_wb_we_i   : cpu_wb_we_i;
        win_addr  = (win_grant == GRANT_DMA) ? dma_wb_addr_i : cpu_wb_addr_i;
        win_wdata = (win_grant == GRANT_DMA) ? dma_wb_data_i : cpu_wb_data_i;
    end

    // Arbitration FSM with registered RAM request and master responses.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= StIdle;
            last_grant_q <= GRANT_DMA;
            ram_stb_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_ack_q    <= 1'b0;
            dma_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            cpu_err_q    <= 1'b0;
            dma_err_q    <= 1'b0;
`endif
        end else begin
            // Master acks/errors are single-cycle pulses.
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cpu_err_q <= 1'b0;
            dma_err_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (cpu_wb_stb_i || dma_wb_stb_i) begin
                        last_grant_q <= win_grant;
                        ram_stb_q    <= 1'b1;
                        ram_we_q     <= win_we;
                        ram_addr_q   <= win_addr;
                        ram_wdata_q  <= win_wdata;
                        state_q      <= StBusy;
                    end
                end
                StBusy: begin
                    if (ram_wb_ack_i) begin
                        ram_stb_q <= 1'b0;
                        state_q   <= StDone;
                        if (last_grant_q == GRANT_DMA) begin
                            dma_ack_q   <= 1'b1;
                            dma_rdata_q <= ram_wb_data_i;
                        end else begin
                            cpu_ack_q   <= 1'b1;
                            cpu_rdata_q <= ram_wb_data_i;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        ram_stb_q <= 1'b0;
                        state_q   <= StDone;
                        if (last_grant_q == GRANT_DMA) begin
                            dma_ack_q   <= 1'b1;
                            dma_err_q   <= 1'b1;
                            dma_rdata_q <= '0;
                        end else begin
                            cpu_ack_q   <= 1'b1;
                            cpu_err_q   <= 1'b1;
                            cpu_rdata_q <= '0;
                        end
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ram_wb_stb_o  = ram_stb_q;
    assign ram_wb_we_o   = ram_we_q;
    assign ram_wb_addr_o = ram_addr_q;
    assign ram_wb_data_o = ram_wdata_q;
    assign cpu_wb_ack_o  = cpu_ack_q;
    assign cpu_wb_data_o = cpu_rdata_q;
    assign dma_wb_ack_o  = dma_ack_q;
    assign dma_wb_data_o = dma_rdata_q;

`ifdef ARB_TIMEOUT_EN
    assign cpu_wb_err_o = cpu_err_q;
    assign dma_wb_err_o = dma_err_q;
`else
    assign cpu_wb_err_o = 1'b0;
    assign dma_wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: table of single transfers with
// expected owner, plus hand sequences for reset, spurious ack, dropped stb and
// an unresponsive RAM. Master acks are checked against a scoreboard queue.
module tb_ram_port_arbiter;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              cpu_wb_stb_i = 1'b0, cpu_wb_we_i = 1'b0;
    logic [ADDR_W-1:0] cpu_wb_addr_i = '0;
    logic [DATA_W-1:0] cpu_wb_data_i = '0;
    logic              cpu_wb_ack_o, cpu_wb_err_o;
    logic [DATA_W-1:0] cpu_wb_data_o;
    logic              dma_wb_stb_i = 1'b0, dma_wb_we_i = 1'b0;
    logic [ADDR_W-1:0] dma_wb_addr_i = '0;
    logic [DATA_W-1:0] dma_wb_data_i = '0;
    logic              dma_wb_ack_o, dma_wb_err_o;
    logic [DATA_W-1:0] dma_wb_data_o;
    logic              ram_wb_stb_o, ram_wb_we_o;
    logic [ADDR_W-1:0] ram_wb_addr_o;
    logic [DATA_W-1:0] ram_wb_data_o;
    logic              ram_wb_ack_i = 1'b0;
    logic [DATA_W-1:0] ram_wb_data_i = '0;

    always #5 sys_clk = ~sys_clk;

    ram_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .cpu_wb_stb_i  (cpu_wb_stb_i),
        .cpu_wb_we_i   (cpu_wb_we_i),
        .cpu_wb_addr_i (cpu_wb_addr_i),
        .cpu_wb_data_i (cpu_wb_data_i),
        .cpu_wb_ack_o  (cpu_wb_ack_o),
        .cpu_wb_data_o (cpu_wb_data_o),
        .cpu_wb_err_o  (cpu_wb_err_o),
        .dma_wb_stb_i  (dma_wb_stb_i),
        .dma_wb_we_i   (dma_wb_we_i),
        .dma_wb_addr_i (dma_wb_addr_i),
        .dma_wb_data_i (dma_wb_data_i),
        .dma_wb_ack_o  (dma_wb_ack_o),
        .dma_wb_data_o (dma_wb_data_o),
        .dma_wb_err_o  (dma_wb_err_o),
        .ram_wb_stb_o  (ram_wb_stb_o),
        .ram_wb_we_o   (ram_wb_we_o),
        .ram_wb_addr_o (ram_wb_addr_o),
        .ram_wb_data_o (ram_wb_data_o),
        .ram_wb_ack_i  (ram_wb_ack_i),
        .ram_wb_data_i (ram_wb_data_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected master acks (who: 0 = CPU, 1 = DMA).
    typedef struct packed {
        logic              who;
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_ack_t;
    exp_ack_t sb_q[$];

    // Every master ack must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (cpu_wb_ack_o || dma_wb_ack_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", {62'd0, cpu_wb_ack_o, dma_wb_ack_o}, 64'd0);
            end else begin
                exp_ack_t e;
                e = sb_q.pop_front();
                check("ack_owner", {62'd0, cpu_wb_ack_o, dma_wb_ack_o},
                      e.who ? 64'd1 : 64'd2);
                check("ack_data", e.who ? dma_wb_data_o : cpu_wb_data_o, e.data);
                check("ack_err", e.who ? dma_wb_err_o : cpu_wb_err_o, e.err);
            end
        end
    end

    typedef struct {
        logic              cpu_stb, cpu_we;
        logic [ADDR_W-1:0] cpu_addr;
        logic [DATA_W-1:0] cpu_wdata;
        logic              dma_stb, dma_we;
        logic [ADDR_W-1:0] dma_addr;
        logic [DATA_W-1:0] dma_wdata;
        logic [DATA_W-1:0] rdata;
        int                wait_cyc;
        logic              exp_dma;  // expected owner
    } vec_t;

    function automatic vec_t mk(input logic cs, input logic cw, input logic [15:0] ca,
                                input logic [31:0] cd, input logic ds, input logic dw,
                                input logic [15:0] da, input logic [31:0] dd,
                                input logic [31:0] rd, input int wc, input logic ed);
        vec_t v;
        v.cpu_stb = cs; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
        v.dma_stb = ds; v.dma_we = dw; v.dma_addr = da; v.dma_wdata = dd;
        v.rdata = rd; v.wait_cyc = wc; v.exp_dma = ed;
        return v;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        cpu_wb_stb_i = v.cpu_stb; cpu_wb_we_i = v.cpu_we;
        cpu_wb_addr_i = v.cpu_addr; cpu_wb_data_i = v.cpu_wdata;
        dma_wb_stb_i = v.dma_stb; dma_wb_we_i = v.dma_we;
        dma_wb_addr_i = v.dma_addr; dma_wb_data_i = v.dma_wdata;
    endtask

    // One complete transfer; entered with the DUT in IDLE, leaves it in IDLE.
    task automatic do_xfer(input vec_t v, input string tag);
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic              ew;
        ea = v.exp_dma ? v.dma_addr  : v.cpu_addr;
        ed = v.exp_dma ? v.dma_wdata : v.cpu_wdata;
        ew = v.exp_dma ? v.dma_we    : v.cpu_we;
        drive(v);
        sb_q.push_back('{who: v.exp_dma, err: 1'b0, data: v.rdata});
        tick();
        check({tag, "_stb"}, ram_wb_stb_o, 1'b1);
        check({tag, "_addr"}, ram_wb_addr_o, ea);
        check({tag, "_wdata"}, ram_wb_data_o, ed);
        check({tag, "_we"}, ram_wb_we_o, ew);
        for (int i = 0; i < v.wait_cyc; i++) begin
            tick();
            check({tag, "_hold_stb"}, ram_wb_stb_o, 1'b1);
            check({tag, "_hold_addr"}, ram_wb_addr_o, ea);
        end
        ram_wb_ack_i  = 1'b1;
        ram_wb_data_i = v.rdata;
        tick();
        ram_wb_ack_i  = 1'b0;
        ram_wb_data_i = 32'h5A5A_0000;
        check({tag, "_done_stb"}, ram_wb_stb_o, 1'b0);
        check({tag, "_done_ack"}, {cpu_wb_ack_o, dma_wb_ack_o}, v.exp_dma ? 2'b01 : 2'b10);
        tick();
        check({tag, "_idle_ack"}, {cpu_wb_ack_o, dma_wb_ack_o}, 2'b00);
        check({tag, "_idle_stb"}, ram_wb_stb_o, 1'b0);
    endtask

    vec_t vecs[9];

    initial begin
        int hi_cnt;
        vec_t v;
        // Owner sequence from reset (last_grant = DMA): C C D C D D C D C
        vecs[0] = mk(1, 1, 16'h0100, 32'h1111_1111, 1, 1, 16'h0200, 32'h2222_2222,
                     32'hA000_0001, 0, 0);
        vecs[1] = mk(1, 0, 16'h8010, 32'h0, 0, 0, 16'h0, 32'h0, 32'hDEAD_BEEF, 1, 0);
        vecs[2] = mk(1, 1, 16'h0104, 32'h1111_0002, 1, 1, 16'h0204, 32'h2222_0002,
                     32'hA000_0002, 0, 1);
        vecs[3] = mk(1, 1, 16'h0108, 32'h1111_0003, 1, 1, 16'h0208, 32'h2222_0003,
                     32'hA000_0003, 0, 0);
        vecs[4] = mk(1, 1, 16'h010C, 32'h1111_0004, 1, 1, 16'h020C, 32'h2222_0004,
                     32'hA000_0004, 2, 1);
        vecs[5] = mk(0, 0, 16'h0, 32'h0, 1, 0, 16'h0300, 32'h0, 32'hCAFE_F00D, 3, 1);
        vecs[6] = mk(1, 1, 16'h0400, 32'h3333_3333, 0, 0, 16'h0, 32'h0, 32'hA000_0006, 0, 0);
        vecs[7] = mk(1, 0, 16'h0410, 32'h0, 1, 1, 16'h0500, 32'h4444_4444, 32'hA000_0007, 1, 1);
        vecs[8] = mk(1, 0, 16'h0414, 32'h0, 1, 1, 16'h0504, 32'h4444_5555, 32'hB000_0008, 0, 0);

        // Reset held with both masters requesting: everything stays zero.
        drive(vecs[0]);
        tick();
        tick();
        check("rst_ram_stb", ram_wb_stb_o, 1'b0);
        check("rst_ram_we", ram_wb_we_o, 1'b0);
        check("rst_ram_addr", ram_wb_addr_o, '0);
        check("rst_ram_data", ram_wb_data_o, '0);
        check("rst_acks", {cpu_wb_ack_o, dma_wb_ack_o, cpu_wb_err_o, dma_wb_err_o}, 4'b0);
        check("rst_rdata", {cpu_wb_data_o, dma_wb_data_o}, 64'd0);
        #3 sys_rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_xfer(vecs[i], $sformatf("v%0d", i));
        end

        // Spurious RAM ack while idle: no request, no response.
        drive(mk(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 32'h0, 0, 0));
        ram_wb_ack_i  = 1'b1;
        ram_wb_data_i = 32'hBAD0_BAD0;
        tick();
        check("spur_stb0", ram_wb_stb_o, 1'b0);
        tick();
        check("spur_stb1", ram_wb_stb_o, 1'b0);
        ram_wb_ack_i = 1'b0;
        // State must still be IDLE: the next request is granted immediately.
        do_xfer(mk(1, 0, 16'h0600, 32'h0, 0, 0, 16'h0, 32'h0, 32'h1234_5678, 0, 0), "spur_x");

        // DMA drops stb mid-transfer: the transfer still completes with an ack.
        drive(mk(0, 0, 16'h0, 32'h0, 1, 1, 16'h0700, 32'h7777_7777, 32'h0, 0, 1));
        sb_q.push_back('{who: 1'b1, err: 1'b0, data: 32'h0F0F_0F0F});
        tick();
        check("drop_stb", ram_wb_stb_o, 1'b1);
        dma_wb_stb_i  = 1'b0;
        dma_wb_addr_i = 16'hFFFF;
        tick();
        check("drop_hold_stb", ram_wb_stb_o, 1'b1);
        check("drop_hold_addr", ram_wb_addr_o, 16'h0700);
        ram_wb_ack_i  = 1'b1;
        ram_wb_data_i = 32'h0F0F_0F0F;
        tick();
        ram_wb_ack_i = 1'b0;
        check("drop_ack", dma_wb_ack_o, 1'b1);
        tick();

        // Reset while a DMA write is in BUSY: request drops at once, no ack.
        drive(mk(0, 0, 16'h0, 32'h0, 1, 1, 16'h0800, 32'h8888_8888, 32'h0, 0, 1));
        tick();
        check("abort_stb", ram_wb_stb_o, 1'b1);
        tick();
        #2 sys_rst = 1'b0;
        #1;
        check("abort_async_stb", ram_wb_stb_o, 1'b0);
        check("abort_async_addr", ram_wb_addr_o, '0);
        cpu_wb_stb_i = 1'b1;
        ram_wb_ack_i = 1'b1;
        tick();
        ram_wb_ack_i = 1'b0;
        tick();
        check("abort_no_ack", {cpu_wb_ack_o, dma_wb_ack_o}, 2'b00);
        #3 sys_rst = 1'b1;
        do_xfer(mk(1, 0, 16'h0900, 32'h0, 1, 1, 16'h0800, 32'h8888_8888,
                   32'h9999_0000, 0, 0), "post_rst");

        // RAM never acks.
        v = mk(1, 0, 16'h0A00, 32'h0, 0, 0, 16'h0, 32'h0, 32'h0, 0, 0);
        drive(v);
        ram_wb_data_i = 32'hFFFF_FFFF;
        hi_cnt = 0;
`ifdef ARB_TIMEOUT_EN
        sb_q.push_back('{who: 1'b0, err: 1'b1, data: 32'h0});
        tick();
        cpu_wb_stb_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ram_wb_stb_o) hi_cnt++;
            tick();
        end
        check("timeout_stb_cycles", hi_cnt, TIMEOUT);
`else
        tick();
        for (int i = 0; i < 300; i++) begin
            if (ram_wb_stb_o) hi_cnt++;
            tick();
        end
        check("hang_stb_cycles", hi_cnt, 300);
        sys_rst = 1'b0;
        cpu_wb_stb_i = 1'b0;
        #1;
        check("hang_rst_stb", ram_wb_stb_o, 1'b0);
        tick();
        #3 sys_rst = 1'b1;
`endif
        tick();
        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
